// File: rtl/tl_ul_mem_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_mem_responder
//
// TileLink-UL manager for a 32-bit master port. A-channel requests (PutFull,
// PutPartial, Get) are served from a word-addressed RAM window starting at
// BASE. Responses go through a 2-entry FIFO so the D channel can apply
// backpressure without losing requests. Every request is fully processed at
// its A-fire edge, and its response sits at the D head no earlier than the
// next cycle.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   io_a_valid/io_a_ready  A handshake (ready depends on registered state only)
//   io_a_bits_*            opcode, param (ignored), size, source, address,
//                          mask, data
//   io_d_valid/io_d_ready  D handshake
//   io_d_bits_*            opcode, param (0), size, source, sink (0), addr_lo,
//                          data, error -- all driven from the FIFO head register
// ---------------------------------------------------------------------------
module tl_ul_mem_responder #(
  parameter logic [31:0] BASE  = 32'h0001_0000,
  parameter int          DEPTH = 1024,
  parameter int          SRC_W = 2
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             io_a_valid,
  output logic             io_a_ready,
  input  logic [2:0]       io_a_bits_opcode,
  input  logic [2:0]       io_a_bits_param,
  input  logic [3:0]       io_a_bits_size,
  input  logic [SRC_W-1:0] io_a_bits_source,
  input  logic [31:0]      io_a_bits_address,
  input  logic [3:0]       io_a_bits_mask,
  input  logic [31:0]      io_a_bits_data,

  output logic             io_d_valid,
  input  logic             io_d_ready,
  output logic [2:0]       io_d_bits_opcode,
  output logic [1:0]       io_d_bits_param,
  output logic [3:0]       io_d_bits_size,
  output logic [SRC_W-1:0] io_d_bits_source,
  output logic [SRC_W-1:0] io_d_bits_sink,
  output logic [1:0]       io_d_bits_addr_lo,
  output logic [31:0]      io_d_bits_data,
  output logic             io_d_bits_error
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BASE_33  = {1'b0, BASE};
  // 33-bit limit so a window ending at 2^32 does not wrap to zero.
  localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(4 * DEPTH);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [3:0]       size;
    logic [SRC_W-1:0] source;
    logic [1:0]       addr_lo;
    logic [31:0]      data;
    logic             error;
  } rsp_t;

  // Queue state: head_reg is the visible D entry, tail_reg the second slot.
  logic [1:0] count_reg;
  rsp_t       head_reg;
  rsp_t       tail_reg;

  logic a_fire;
  logic d_fire;

  assign io_a_ready = !reset && (count_reg < 2'd2);
  assign io_d_valid = (count_reg != 2'd0);
  assign a_fire     = io_a_valid && io_a_ready;
  assign d_fire     = io_d_valid && io_d_ready;

  // ---------------- request decode / legality ----------------
  logic             opcode_ok;
  logic             size_ok;
  logic             align_ok;
  logic             range_ok;
  logic             legal;
  logic             is_put;
  logic             is_get;
  logic [32:0]      addr_33;
  logic [32:0]      offset_33;
  logic [IDX_W-1:0] word_idx;
  logic             ram_we;
  logic [31:0]      ram_rdata;
  rsp_t             rsp_new;

  assign opcode_ok = (io_a_bits_opcode == 3'd0) || (io_a_bits_opcode == 3'd1) ||
                     (io_a_bits_opcode == 3'd4);
  assign size_ok   = (io_a_bits_size <= 4'd2);

  always_comb begin
    align_ok = 1'b0;
    case (io_a_bits_size)
      4'd0:    align_ok = 1'b1;
      4'd1:    align_ok = (io_a_bits_address[0] == 1'b0);
      default: align_ok = (io_a_bits_address[1:0] == 2'b00);
    endcase
  end

  assign addr_33   = {1'b0, io_a_bits_address};
  assign range_ok  = (addr_33 >= BASE_33) && (addr_33 < LIMIT_33);
  assign offset_33 = addr_33 - BASE_33;
  assign word_idx  = offset_33[IDX_W+1:2];

  assign legal  = opcode_ok && size_ok && align_ok && range_ok;
  assign is_put = legal && (io_a_bits_opcode == 3'd0 || io_a_bits_opcode == 3'd1);
  assign is_get = legal && (io_a_bits_opcode == 3'd4);
  assign ram_we = a_fire && is_put;

  // Bits that carry no information for this window.
  logic unused_ok;
  assign unused_ok = ^{io_a_bits_param, offset_33[32:IDX_W+2], offset_33[1:0]};

  // ---------------- RAM: one byte-wide array per lane ----------------
  // The read is asynchronous here and captured into the queue register at the
  // fire edge, so a Get sees the word as it stood before that edge.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
      if (ram_we && io_a_bits_mask[gi]) begin
        mem[word_idx] <= io_a_bits_data[gi*8 +: 8];
      end
    end

    assign ram_rdata[gi*8 +: 8] = mem[word_idx];
  end

  // ---------------- response formation ----------------
  always_comb begin
    rsp_new         = '0;
    rsp_new.size    = io_a_bits_size;
    rsp_new.source  = io_a_bits_source;
    rsp_new.addr_lo = io_a_bits_address[1:0];
    rsp_new.error   = !legal;
    if (legal) begin
      rsp_new.opcode = is_get ? 3'd1 : 3'd0;
      rsp_new.data   = is_get ? ram_rdata : 32'd0;
    end else begin
      // Rejected requests that would have carried data back still answer
      // with AccessAckData (data 0); everything else gets a plain AccessAck.
      rsp_new.opcode = (io_a_bits_opcode == 3'd4 || io_a_bits_opcode == 3'd2 ||
                        io_a_bits_opcode == 3'd3) ? 3'd1 : 3'd0;
      rsp_new.data   = 32'd0;
    end
  end

  // ---------------- 2-entry response FIFO ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case ({a_fire, d_fire})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= rsp_new;
          else                   tail_reg <= rsp_new;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Both fire only with count==1 (a_ready needs <2, d_valid needs >0),
          // so the new response replaces the departing head.
          head_reg <= rsp_new;
        end
        default: ;
      endcase
    end
  end

  assign io_d_bits_opcode  = head_reg.opcode;
  assign io_d_bits_param   = 2'd0;
  assign io_d_bits_size    = head_reg.size;
  assign io_d_bits_source  = head_reg.source;
  assign io_d_bits_sink    = '0;
  assign io_d_bits_addr_lo = head_reg.addr_lo;
  assign io_d_bits_data    = head_reg.data;
  assign io_d_bits_error   = head_reg.error;

endmodule
